serial_packet_receiver: RTL and testbench
=========================================

SERIAL_PACKET_RECEIVER -- requirements
Module: serial_packet_receiver

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per serial bit (115200 baud at 100 MHz); legal range is 4 or more.
REQ-002 The block SHALL have parameter HEADER_BYTE, default 8'hAA, meaning the packet start byte.
REQ-003 The block SHALL have parameter TIMEOUT_CLKS, default 100000, meaning the maximum idle clk cycles allowed between bytes inside a packet.
REQ-004 Port clk  input  1  system clock; the only clock in the block.
REQ-005 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port serial_rx  input  1  asynchronous 8N1 line, LSB first, idle high; this is the consumer of the controller's serial_tx output.
REQ-007 Port temp_data  output  16  last accepted temperature word.
REQ-008 Port hum_data  output  16  last accepted humidity word.
REQ-009 Port motion_data  output  16  last accepted motion word.
REQ-010 Port valid_flags  output  3  {motion, hum, temp} flags from the last accepted packet.
REQ-011 Port packet_valid  output  1  one-cycle pulse when a packet is accepted.
REQ-012 Port checksum_error  output  1  one-cycle pulse when a packet is rejected for a bad checksum.
REQ-013 Port framing_error  output  1  one-cycle pulse when a stop bit is sampled low.
REQ-014 Port timeout_error  output  1  one-cycle pulse when the inter-byte timeout expires.
REQ-015 Port rx_busy  output  1  high while the parser is in any state other than HUNT.

Function
REQ-016 serial_rx SHALL pass through a 2-flop synchronizer before any use; all timing below is measured on the synchronized signal.
REQ-017 Bit receiver states SHALL be IDLE, START, DATA, STOP.
- IDLE -> START on a synchronized high-to-low transition.
REQ-018 In START the line SHALL be sampled at CLKS_PER_BIT/2 (integer division).
- Sample low: go to DATA.
- Sample high: treat as a glitch and return to IDLE with no error.
REQ-019 In DATA, 8 bits SHALL be sampled at CLKS_PER_BIT intervals after the start-bit midpoint, LSB first, using a 3-bit index.
REQ-020 In STOP the line SHALL be sampled once more.
- High: emit an internal byte strobe with the 8-bit value.
- Low: pulse framing_error, discard the byte, force the parser to HUNT.
- In both cases return to IDLE.
REQ-021 The packet SHALL be 9 bytes: HEADER_BYTE, flags, temp_hi, temp_lo, hum_hi, hum_lo, motion_hi, motion_lo, checksum.
REQ-022 The checksum SHALL be the 8-bit XOR of bytes 1 through 7 (flags through motion_lo).
REQ-023 Parser states SHALL be HUNT, FLAGS, PAYLOAD, CHECK.
- HUNT: bytes other than HEADER_BYTE are ignored silently.
- HUNT -> FLAGS on a strobed byte equal to HEADER_BYTE.
- FLAGS -> PAYLOAD on the next byte.
- PAYLOAD uses a 3-bit counter 0..5 and goes to CHECK after the 6th byte.
- CHECK -> HUNT on the next byte.
REQ-024 A HEADER_BYTE value received in FLAGS, PAYLOAD or CHECK SHALL be treated as data, not as a resynchronization.
REQ-025 The running XOR SHALL clear on header detection and accumulate bytes 1..7.
- Payload bytes SHALL be held in shadow registers; no output is updated before the checksum passes.
REQ-026 On a checksum match, in the cycle after the checksum byte strobe:
- temp_data, hum_data, motion_data and valid_flags (flags[2:0]) SHALL update;
- packet_valid SHALL pulse for exactly one cycle.
REQ-027 On a checksum mismatch the outputs SHALL hold their values and checksum_error SHALL pulse for one cycle, at the same latency as packet_valid.
REQ-028 Flags bits [7:3] SHALL be included in the checksum and otherwise ignored.
REQ-029 The timeout counter SHALL reset on every byte strobe and on every start-bit detection, and run only while the parser is not in HUNT.
- Reaching TIMEOUT_CLKS: pulse timeout_error, return the parser to HUNT, discard the partial packet.
REQ-030 At most one of packet_valid, checksum_error, framing_error, timeout_error SHALL be asserted in any cycle.
- framing_error takes priority over timeout_error.
REQ-031 Back-to-back packets with zero idle time between the stop bit and the next start bit SHALL be received without loss.

Reset
REQ-032 While rst_n is low:
- temp_data, hum_data and motion_data SHALL be 16'h0000 and valid_flags 3'b000;
- all pulse outputs and rx_busy SHALL be 0;
- the bit receiver SHALL be in IDLE, the parser in HUNT, and all counters, the XOR accumulator and the shadow registers 0;
- both synchronizer flops SHALL be 1.
REQ-033 Reset asserted mid-byte or mid-packet SHALL abandon it with no error pulse.
- After release, reception SHALL restart at the next start bit while the parser is in HUNT.

Verification (CLKS_PER_BIT=16, TIMEOUT_CLKS=400)
REQ-034 Good packet: send AA 07 01 90 02 26 00 01 B3 -> one packet_valid pulse; temp_data=16'h0190, hum_data=16'h0226, motion_data=16'h0001, valid_flags=3'b111.
REQ-035 Bad checksum: send the same packet with checksum B4 -> one checksum_error pulse; outputs keep their previous values.
REQ-036 Framing error: send AA, then 07 with its stop bit driven low -> framing_error pulse; parser in HUNT; a following good packet is accepted.
REQ-037 Timeout: send AA 07 01, then hold the line idle for 500 clk -> timeout_error pulse; rx_busy falls; no packet_valid.
REQ-038 Noise and embedded header:
- A 5-clk low glitch produces no strobe and no error.
- Send 55 AA 01 AA ... with a valid checksum -> exactly one packet_valid; the AA at byte 3 is stored as temp_lo.
REQ-039 Reset mid-packet: assert rst_n after byte 4 of a packet -> all outputs return to reset values; the next full packet is accepted normally.

Source files
------------

// File: rtl/serial_packet_receiver.sv
// rtl/serial_packet_receiver.sv - 8N1 serial byte receiver feeding a 9-byte sensor packet parser
// Outputs update only after a packet's XOR checksum matches.
module serial_packet_receiver #(
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] HEADER_BYTE  = 8'hAA,
  parameter int         TIMEOUT_CLKS = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        serial_rx,
  output logic [15:0] temp_data,
  output logic [15:0] hum_data,
  output logic [15:0] motion_data,
  output logic [2:0]  valid_flags,
  output logic        packet_valid,
  output logic        checksum_error,
  output logic        framing_error,
  output logic        timeout_error,
  output logic        rx_busy
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam int            TW        = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {P_HUNT, P_FLAGS, P_PAYLOAD, P_CHECK} p_state_t;

  logic          r_rx_meta, r_rx_sync, r_rx_prev;
  rx_state_t     r_rx_state, w_rx_next;
  logic [CW-1:0] r_clk_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;

  p_state_t      r_p_state, w_p_next;
  logic [2:0]    r_pay_cnt;
  logic [7:0]    r_xor;
  logic [2:0]    r_flags;
  logic [47:0]   r_shadow;
  logic [TW-1:0] r_to_cnt;

  logic [15:0]   r_temp, r_hum, r_motion;
  logic [2:0]    r_valid_flags;
  logic          r_packet_valid, r_checksum_error, r_framing_error, r_timeout_error;

  logic w_fall, w_half_hit, w_bit_hit, w_start_det, w_byte_stb, w_frame;
  logic w_timeout, w_accept, w_reject;

  assign w_fall      = r_rx_prev & ~r_rx_sync;
  assign w_half_hit  = (r_clk_cnt == HALF_LAST);
  assign w_bit_hit   = (r_clk_cnt == BIT_LAST);
  assign w_start_det = (r_rx_state == RX_IDLE) && w_fall;
  assign w_byte_stb  = (r_rx_state == RX_STOP) && w_bit_hit && r_rx_sync;
  assign w_frame     = (r_rx_state == RX_STOP) && w_bit_hit && !r_rx_sync;
  // Framing wins over timeout; a strobe or start edge in the same cycle restarts the idle window.
  assign w_timeout   = (r_p_state != P_HUNT) && (r_to_cnt == TO_LAST) &&
                       !w_byte_stb && !w_start_det && !w_frame;
  assign w_accept    = w_byte_stb && (r_p_state == P_CHECK) && (r_shift == r_xor);
  assign w_reject    = w_byte_stb && (r_p_state == P_CHECK) && (r_shift != r_xor);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= serial_rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:  if (w_fall) w_rx_next = RX_START;
      RX_START: if (w_half_hit) w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_bit_hit && r_bit_idx == 3'd7) w_rx_next = RX_STOP;
      RX_STOP:  if (w_bit_hit) w_rx_next = RX_IDLE;
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state <= RX_IDLE;
      r_clk_cnt  <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
    end else begin
      r_rx_state <= w_rx_next;
      if (r_rx_state == RX_IDLE || w_rx_next != r_rx_state || w_bit_hit)
        r_clk_cnt <= '0;
      else
        r_clk_cnt <= r_clk_cnt + CW'(1);
      if (r_rx_state == RX_IDLE)
        r_bit_idx <= '0;
      else if (r_rx_state == RX_DATA && w_bit_hit) begin
        r_shift   <= {r_rx_sync, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 3'd1;
      end
    end
  end

  always_comb begin
    w_p_next = r_p_state;
    if (w_frame || w_timeout)
      w_p_next = P_HUNT;
    else if (w_byte_stb) begin
      case (r_p_state)
        P_HUNT:    if (r_shift == HEADER_BYTE) w_p_next = P_FLAGS;
        P_FLAGS:   w_p_next = P_PAYLOAD;
        P_PAYLOAD: if (r_pay_cnt == 3'd5) w_p_next = P_CHECK;
        P_CHECK:   w_p_next = P_HUNT;
        default:   w_p_next = P_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p_state        <= P_HUNT;
      r_pay_cnt        <= '0;
      r_xor            <= '0;
      r_flags          <= '0;
      r_shadow         <= '0;
      r_to_cnt         <= '0;
      r_temp           <= '0;
      r_hum            <= '0;
      r_motion         <= '0;
      r_valid_flags    <= '0;
      r_packet_valid   <= 1'b0;
      r_checksum_error <= 1'b0;
      r_framing_error  <= 1'b0;
      r_timeout_error  <= 1'b0;
    end else begin
      r_p_state        <= w_p_next;
      r_packet_valid   <= w_accept;
      r_checksum_error <= w_reject;
      r_framing_error  <= w_frame;
      r_timeout_error  <= w_timeout;

      if (w_byte_stb || w_start_det || r_p_state == P_HUNT)
        r_to_cnt <= '0;
      else
        r_to_cnt <= r_to_cnt + TW'(1);

      if (w_byte_stb) begin
        case (r_p_state)
          P_HUNT: begin
            if (r_shift == HEADER_BYTE) begin
              r_xor     <= '0;
              r_pay_cnt <= '0;
            end
          end
          P_FLAGS: begin
            r_flags <= r_shift[2:0];
            r_xor   <= r_xor ^ r_shift;
          end
          P_PAYLOAD: begin
            r_shadow  <= {r_shadow[39:0], r_shift};
            r_xor     <= r_xor ^ r_shift;
            r_pay_cnt <= r_pay_cnt + 3'd1;
          end
          P_CHECK: begin
            if (r_shift == r_xor) begin
              r_temp        <= r_shadow[47:32];
              r_hum         <= r_shadow[31:16];
              r_motion      <= r_shadow[15:0];
              r_valid_flags <= r_flags;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign temp_data      = r_temp;
  assign hum_data       = r_hum;
  assign motion_data    = r_motion;
  assign valid_flags    = r_valid_flags;
  assign packet_valid   = r_packet_valid;
  assign checksum_error = r_checksum_error;
  assign framing_error  = r_framing_error;
  assign timeout_error  = r_timeout_error;
  assign rx_busy        = (r_p_state != P_HUNT);

endmodule

// File: tb/tb_serial_packet_receiver.sv
// tb/tb_serial_packet_receiver.sv - scoreboard bench for serial_packet_receiver
// Expected events come from a packet-level stream model; a monitor pops them on each DUT pulse.
module tb_serial_packet_receiver;

  localparam int CPB = 16;
  localparam int TO  = 400;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        serial_rx;
  logic [15:0] temp_data, hum_data, motion_data;
  logic [2:0]  valid_flags;
  logic        packet_valid, checksum_error, framing_error, timeout_error, rx_busy;

  serial_packet_receiver #(
    .CLKS_PER_BIT(CPB),
    .HEADER_BYTE (8'hAA),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .serial_rx     (serial_rx),
    .temp_data     (temp_data),
    .hum_data      (hum_data),
    .motion_data   (motion_data),
    .valid_flags   (valid_flags),
    .packet_valid  (packet_valid),
    .checksum_error(checksum_error),
    .framing_error (framing_error),
    .timeout_error (timeout_error),
    .rx_busy       (rx_busy)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_PKT = 0, EV_CSUM = 1, EV_FRAME = 2, EV_TOUT = 3} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [15:0] t, h, m;
    logic [2:0]  f;
  } ev_t;

  ev_t         sb[$];
  logic [7:0]  stream[$];
  int          checks = 0;
  int          passes = 0;
  logic [15:0] m_t = '0, m_h = '0, m_m = '0;
  logic [2:0]  m_f = '0;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push(input ev_kind_t k);
    ev_t e;
    e.kind = k; e.t = m_t; e.h = m_h; e.m = m_m; e.f = m_f;
    sb.push_back(e);
  endtask

  // Packet-level view: scan for a header, take the next 8 bytes, XOR-check; a short tail times out.
  task automatic model_stream();
    int i = 0;
    logic [7:0] x;
    logic [7:0] fl;
    while (i < stream.size()) begin
      if (stream[i] != 8'hAA) begin
        i++;
        continue;
      end
      if (stream.size() - i < 9) begin
        push(EV_TOUT);
        break;
      end
      x = 8'h00;
      for (int k = 1; k <= 7; k++) x ^= stream[i+k];
      if (x == stream[i+8]) begin
        fl  = stream[i+1];
        m_f = fl[2:0];
        m_t = {stream[i+2], stream[i+3]};
        m_h = {stream[i+4], stream[i+5]};
        m_m = {stream[i+6], stream[i+7]};
        push(EV_PKT);
      end else begin
        push(EV_CSUM);
      end
      i += 9;
    end
  endtask

  task automatic add_pkt(input logic [7:0] f, input logic [15:0] t, input logic [15:0] h,
                         input logic [15:0] m, input bit bad);
    logic [7:0] b[8];
    logic [7:0] x = 8'h00;
    b[0] = f; b[1] = t[15:8]; b[2] = t[7:0]; b[3] = h[15:8];
    b[4] = h[7:0]; b[5] = m[15:8]; b[6] = m[7:0];
    for (int k = 0; k < 7; k++) x ^= b[k];
    b[7] = bad ? (x ^ 8'h01) : x;
    stream.push_back(8'hAA);
    for (int k = 0; k < 8; k++) stream.push_back(b[k]);
  endtask

  task automatic idle(input int n);
    serial_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    serial_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    serial_rx = stop;
    repeat (CPB) @(negedge clk);
    serial_rx = 1'b1;
  endtask

  task automatic send_stream();
    model_stream();
    foreach (stream[i]) send_byte(stream[i], 1'b1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_temp"}, temp_data, 16'h0000);
    chk({tag, "_hum"}, hum_data, 16'h0000);
    chk({tag, "_motion"}, motion_data, 16'h0000);
    chk({tag, "_flags"}, valid_flags, 3'b000);
    chk({tag, "_pulses"}, {packet_valid, checksum_error, framing_error, timeout_error}, 4'b0000);
    chk({tag, "_busy"}, rx_busy, 1'b0);
  endtask

  ev_t mon_e;
  int  mon_kind;
  always @(negedge clk) begin
    if (rst_n && (packet_valid || checksum_error || framing_error || timeout_error)) begin
      chk("one_pulse", $countones({packet_valid, checksum_error, framing_error, timeout_error}), 1);
      mon_kind = packet_valid ? 0 : checksum_error ? 1 : framing_error ? 2 : 3;
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_pulse: got event %0d expected none", mon_kind);
      end else begin
        mon_e = sb.pop_front();
        chk("event_kind", mon_kind, mon_e.kind);
        chk("temp_data", temp_data, mon_e.t);
        chk("hum_data", hum_data, mon_e.h);
        chk("motion_data", motion_data, mon_e.m);
        chk("valid_flags", valid_flags, mon_e.f);
      end
    end
  end

  initial begin
    logic [7:0] nb;
    rst_n = 1'b0;
    serial_rx = 1'b1;
    repeat (5) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    idle(20);

    stream = '{8'hAA, 8'h07, 8'h01, 8'h90, 8'h02, 8'h26, 8'h00, 8'h01, 8'hB3};
    send_stream();
    idle(50);
    chk("good_temp", temp_data, 16'h0190);
    chk("good_hum", hum_data, 16'h0226);
    chk("good_motion", motion_data, 16'h0001);
    chk("good_flags", valid_flags, 3'b111);

    stream = '{8'hAA, 8'h07, 8'h01, 8'h90, 8'h02, 8'h26, 8'h00, 8'h01, 8'hB4};
    send_stream();
    idle(50);
    chk("badcs_temp_held", temp_data, 16'h0190);

    push(EV_FRAME);
    send_byte(8'hAA, 1'b1);
    send_byte(8'h07, 1'b0);
    idle(50);
    chk("frame_busy", rx_busy, 1'b0);
    stream.delete();
    add_pkt(8'h05, 16'h1234, 16'h5678, 16'h9ABC, 1'b0);
    send_stream();
    idle(50);

    stream = '{8'hAA, 8'h07, 8'h01};
    send_stream();
    idle(5);
    chk("tout_busy_before", rx_busy, 1'b1);
    idle(500);
    chk("tout_busy_after", rx_busy, 1'b0);

    serial_rx = 1'b0;
    repeat (5) @(negedge clk);
    idle(50);
    stream = '{8'h55};
    add_pkt(8'h01, 16'hAAAA, 16'h00AA, 16'hAA00, 1'b0);
    send_stream();
    idle(50);
    chk("embedded_temp", temp_data, 16'hAAAA);

    stream = '{8'hAA, 8'h07, 8'h01, 8'h90};
    foreach (stream[i]) send_byte(stream[i], 1'b1);
    idle(3);
    rst_n = 1'b0;
    m_t = '0; m_h = '0; m_m = '0; m_f = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("midreset");
    chk("midreset_no_pending", sb.size(), 0);
    rst_n = 1'b1;
    idle(20);
    stream.delete();
    add_pkt(8'h02, 16'h0BAD, 16'hF00D, 16'h7777, 1'b0);
    send_stream();
    idle(50);

    for (int it = 0; it < 10; it++) begin
      stream.delete();
      for (int n = $urandom_range(0, 2); n > 0; n--) begin
        do nb = 8'($urandom_range(0, 255)); while (nb == 8'hAA);
        stream.push_back(nb);
      end
      for (int p = $urandom_range(1, 2); p > 0; p--)
        add_pkt(8'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 3) == 0)
        for (int k = $urandom_range(1, 8); k > 0; k--) void'(stream.pop_back());
      send_stream();
      idle(600);
    end

    idle(50);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
